// File: rtl/rs_age_issue_pkg.sv
// Shared constants and helpers for the age-ordered reservation station.
package rs_age_issue_pkg;

   // Default widths used when the station is instantiated without overrides.
   localparam int ROB_W_DEF = 4;
   localparam int XLEN_DEF  = 32;
   localparam int CDB_N_DEF = 2;

   // Opcode classes that the integer pipe accepts.
   typedef enum logic [6:0] {
      OPC_I = 7'b0010011,   // register-immediate ALU
      OPC_R = 7'b0110011,   // register-register ALU
      OPC_B = 7'b1100011    // conditional branch
   } opc_e;

   // Bit offset of channel k inside a packed CDB bus whose fields are w bits wide.
   function automatic int unsigned cdb_lsb(input int unsigned k, input int unsigned w);
      return k * w;
   endfunction

endpackage

// File: rtl/rs_age_matrix.sv
// Age matrix: tracks relative allocation order of the station entries and
// picks the oldest entry among those flagged ready.
module rs_age_matrix #(
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic [DEPTH-1:0]         alloc_oh,
   input  logic [DEPTH-1:0]         free_oh,
   input  logic [DEPTH-1:0]         ready,
   output logic [DEPTH-1:0]         oldest_oh,
   output logic [$clog2(DEPTH)-1:0] oldest_idx,
   output logic                     oldest_valid
);

   localparam int IDX_W = $clog2(DEPTH);

   // older[i][j] = 1 means entry i was allocated before entry j.
   logic [DEPTH-1:0][DEPTH-1:0] older;
   logic [DEPTH-1:0]            valid;
   logic [DEPTH-1:0]            blocked;

   // Update order relations: a new entry is younger than every live one;
   // a freed entry drops out of both its row and its column.
   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so every bit
      // samples the pre-edge values regardless of statement order.
      if (rst || flush) begin
         older <= '0;
         valid <= '0;
      end else begin
         valid <= (valid | alloc_oh) & ~free_oh;
         for (int i = 0; i < DEPTH; i++) begin
            for (int j = 0; j < DEPTH; j++) begin
               if (free_oh[i] || free_oh[j])
                  older[i][j] <= 1'b0;
               else if (alloc_oh[j])
                  older[i][j] <= valid[i];
               else if (alloc_oh[i])
                  older[i][j] <= 1'b0;
            end
         end
      end
   end

   // An entry is blocked when any older entry is also ready.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path
      // leaves it unassigned and infers a latch.
      blocked = '0;
      for (int i = 0; i < DEPTH; i++) begin
         for (int j = 0; j < DEPTH; j++) begin
            if (ready[j] && older[j][i])
               blocked[i] = 1'b1;
         end
      end
   end

   // Oldest-ready one-hot and its binary index; live entries are totally
   // ordered, so at most one bit survives.
   always_comb begin
      oldest_oh    = ready & ~blocked;
      oldest_valid = |ready;
      oldest_idx   = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (oldest_oh[i])
            oldest_idx = IDX_W'(i);
      end
   end

endmodule

// File: rtl/rs_age_issue.sv
// Reservation station for the integer pipe: captures operands from the CDB,
// issues the oldest operand-ready micro-op to the ALU over valid/ready.
module rs_age_issue
   import rs_age_issue_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int ROB_W = ROB_W_DEF,
   parameter int CDB_N = CDB_N_DEF,
   parameter int XLEN  = XLEN_DEF
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      rdy,
   input  logic                      flush,
   input  logic                      alloc_valid,
   input  logic [2:0]                alloc_op,
   input  logic [6:0]                alloc_type,
   input  logic                      alloc_alt,
   input  logic [XLEN-1:0]           alloc_v1,
   input  logic [XLEN-1:0]           alloc_v2,
   input  logic                      alloc_dep1,
   input  logic                      alloc_dep2,
   input  logic [ROB_W-1:0]          alloc_q1,
   input  logic [ROB_W-1:0]          alloc_q2,
   input  logic [ROB_W-1:0]          alloc_dest,
   output logic                      full,
   output logic [$clog2(DEPTH):0]    count,
   input  logic [CDB_N-1:0]          cdb_valid,
   input  logic [CDB_N*ROB_W-1:0]    cdb_tag,
   input  logic [CDB_N*XLEN-1:0]     cdb_value,
   output logic                      issue_valid,
   input  logic                      issue_ready,
   output logic [2:0]                issue_op,
   output logic [6:0]                issue_type,
   output logic                      issue_alt,
   output logic [XLEN-1:0]           issue_v1,
   output logic [XLEN-1:0]           issue_v2,
   output logic [ROB_W-1:0]          issue_dest
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int CNT_W = IDX_W + 1;

   typedef struct packed {
      logic            hit;
      logic [XLEN-1:0] val;
   } cdb_hit_t;

   // Control state (reset/flushed).
   logic [DEPTH-1:0] busy;
   logic [DEPTH-1:0] dep1;
   logic [DEPTH-1:0] dep2;
   logic [CNT_W-1:0] count_r;

   // Payload storage (never reset).
   logic [ROB_W-1:0] q1_r   [DEPTH];
   logic [ROB_W-1:0] q2_r   [DEPTH];
   logic [ROB_W-1:0] dest_r [DEPTH];
   logic [XLEN-1:0]  v1_r   [DEPTH];
   logic [XLEN-1:0]  v2_r   [DEPTH];
   logic [2:0]       op_r   [DEPTH];
   logic [6:0]       type_r [DEPTH];
   logic [DEPTH-1:0] alt_r;

   logic [DEPTH-1:0] free_slot_oh;
   logic [DEPTH-1:0] alloc_wr;
   logic [DEPTH-1:0] free_wr;
   logic [DEPTH-1:0] ready_vec;
   logic [DEPTH-1:0] sel_oh;
   logic [IDX_W-1:0] sel_idx;
   logic             sel_valid;
   logic             alloc_fire;
   logic             issue_fire;

   cdb_hit_t wk1 [DEPTH];
   cdb_hit_t wk2 [DEPTH];
   cdb_hit_t byp1;
   cdb_hit_t byp2;

   // Search all broadcast channels for a tag; the lowest channel wins.
   function automatic cdb_hit_t cdb_lookup(input logic [ROB_W-1:0] tag);
      cdb_hit_t r;
      r = '0;
      for (int k = CDB_N - 1; k >= 0; k--) begin
         if (cdb_valid[k] && cdb_tag[cdb_lsb(k, ROB_W) +: ROB_W] == tag) begin
            r.hit = 1'b1;
            r.val = cdb_value[cdb_lsb(k, XLEN) +: XLEN];
         end
      end
      return r;
   endfunction

   assign full      = (count_r == CNT_W'(DEPTH));
   assign count     = count_r;
   assign ready_vec = busy & ~dep1 & ~dep2;

   assign alloc_fire = rdy && alloc_valid && !full;
   assign issue_fire = rdy && sel_valid && issue_ready;
   assign alloc_wr   = alloc_fire ? free_slot_oh : '0;
   assign free_wr    = issue_fire ? sel_oh : '0;

   // Lowest-index free slot, from registered occupancy only.
   always_comb begin
      free_slot_oh = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (!busy[i]) begin
            free_slot_oh    = '0;
            free_slot_oh[i] = 1'b1;
         end
      end
   end

   // CDB matches for stored tags and for the incoming micro-op's tags.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         wk1[i] = cdb_lookup(q1_r[i]);
         wk2[i] = cdb_lookup(q2_r[i]);
      end
      byp1 = cdb_lookup(alloc_q1);
      byp2 = cdb_lookup(alloc_q2);
   end

   // Occupancy, pending-operand bits and count.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         busy    <= '0;
         dep1    <= '0;
         dep2    <= '0;
         count_r <= '0;
      end else if (rdy) begin
         busy    <= (busy | alloc_wr) & ~free_wr;
         count_r <= count_r + CNT_W'(alloc_fire) - CNT_W'(issue_fire);
         for (int i = 0; i < DEPTH; i++) begin
            if (alloc_wr[i]) begin
               dep1[i] <= alloc_dep1 && !byp1.hit;
               dep2[i] <= alloc_dep2 && !byp2.hit;
            end else begin
               if (busy[i] && dep1[i] && wk1[i].hit)
                  dep1[i] <= 1'b0;
               if (busy[i] && dep2[i] && wk2[i].hit)
                  dep2[i] <= 1'b0;
            end
         end
      end
   end

   // Payload writes on allocation and operand capture on wakeup.
   always_ff @(posedge clk) begin
      // NOTE: payload arrays carry no reset; busy/dep bits gate every use,
      // so stale contents are harmless and the storage stays plain RAM.
      if (rdy) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (alloc_wr[i]) begin
               op_r[i]   <= alloc_op;
               type_r[i] <= alloc_type;
               alt_r[i]  <= alloc_alt;
               dest_r[i] <= alloc_dest;
               q1_r[i]   <= alloc_q1;
               q2_r[i]   <= alloc_q2;
               v1_r[i]   <= (alloc_dep1 && byp1.hit) ? byp1.val : alloc_v1;
               v2_r[i]   <= (alloc_dep2 && byp2.hit) ? byp2.val : alloc_v2;
            end else begin
               if (busy[i] && dep1[i] && wk1[i].hit)
                  v1_r[i] <= wk1[i].val;
               if (busy[i] && dep2[i] && wk2[i].hit)
                  v2_r[i] <= wk2[i].val;
            end
         end
      end
   end

   rs_age_matrix #(
      .DEPTH (DEPTH)
   ) u_age (
      .clk          (clk),
      .rst          (rst),
      .flush        (flush),
      .alloc_oh     (alloc_wr),
      .free_oh      (free_wr),
      .ready        (ready_vec),
      .oldest_oh    (sel_oh),
      .oldest_idx   (sel_idx),
      .oldest_valid (sel_valid)
   );

   // Issue port: fields of the selected entry, zeroed when nothing is ready.
   always_comb begin
      issue_valid = sel_valid;
      issue_op    = '0;
      issue_type  = '0;
      issue_alt   = 1'b0;
      issue_v1    = '0;
      issue_v2    = '0;
      issue_dest  = '0;
      if (sel_valid) begin
         issue_op   = op_r[sel_idx];
         issue_type = type_r[sel_idx];
         issue_alt  = alt_r[sel_idx];
         issue_v1   = v1_r[sel_idx];
         issue_v2   = v2_r[sel_idx];
         issue_dest = dest_r[sel_idx];
      end
   end

endmodule
